// File: rtl/stg5wb_pkg.sv
// Shared sizes and opcode constants for the write-back stage.
// Widths mirror the existing sizes header; OPC_S_HLT comes from the shared opcode header.
package stg5wb_pkg;
    localparam int SIZE_DATA = 24;
    localparam int SIZE_ADDR = 24;
    localparam int SIZE_OPC  = 8;

    typedef logic [SIZE_OPC-1:0] opc_t;

    localparam opc_t OPC_BUBBLE = 8'h00;
    localparam opc_t OPC_S_HLT  = 8'h7F;

    function automatic logic is_bubble(input opc_t opc);
        return opc == OPC_BUBBLE;
    endfunction
endpackage

// File: rtl/stg5wb_regfile_bypass.sv
// Register file: one write port, N combinational read ports that see a
// same-cycle write (write-through bypass), asynchronous active-high reset.
module regfile_bypass #(
    parameter int DW   = 24,
    parameter int AW   = 4,
    parameter int N_RD = 2
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [N_RD-1:0][AW-1:0]  i_rd_addr,
    output logic [N_RD-1:0][DW-1:0]  o_rd_data
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];

    // Flop array rather than RAM: every entry must clear on reset.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
            logic w_hit;
            assign w_hit         = i_we && (i_waddr == i_rd_addr[gi]);
            assign o_rd_data[gi] = w_hit ? i_wdata : r_mem[i_rd_addr[gi]];
        end
    endgenerate
endmodule

// File: rtl/stg5wb.sv
// Pipeline stage 5 (write-back): owns the GP/SR register files, forwards the
// last committed result, counts retired instructions and latches halt.
module stg5wb
    import stg5wb_pkg::*;
#(
    parameter int DATA_W   = SIZE_DATA,
    parameter int ADDR_W   = SIZE_ADDR,
    parameter int OPC_W    = SIZE_OPC,
    parameter int TGT_GP_W = 4,
    parameter int TGT_SR_W = 2,
    parameter int CNT_W    = 32
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic [ADDR_W-1:0]   iw_pc,
    input  logic [DATA_W-1:0]   iw_instr,
    input  logic [OPC_W-1:0]    iw_opc,
    input  logic [TGT_GP_W-1:0] iw_tgt_gp,
    input  logic                iw_tgt_gp_we,
    input  logic [TGT_SR_W-1:0] iw_tgt_sr,
    input  logic                iw_tgt_sr_we,
    input  logic [DATA_W-1:0]   iw_result,
    input  logic [TGT_GP_W-1:0] iw_rd_gp_a,
    output logic [DATA_W-1:0]   ow_rd_gp_a,
    input  logic [TGT_GP_W-1:0] iw_rd_gp_b,
    output logic [DATA_W-1:0]   ow_rd_gp_b,
    input  logic [TGT_SR_W-1:0] iw_rd_sr,
    output logic [DATA_W-1:0]   ow_rd_sr,
    output logic [TGT_GP_W-1:0] ow_fwd_gp,
    output logic                ow_fwd_gp_we,
    output logic [DATA_W-1:0]   ow_fwd_result,
    output logic [CNT_W-1:0]    ow_retired,
    output logic                ow_halted,
    output logic [ADDR_W-1:0]   ow_halt_pc
);
    logic                      r_halted;
    logic [ADDR_W-1:0]         r_halt_pc;
    logic [CNT_W-1:0]          r_retired;
    logic [TGT_GP_W-1:0]       r_fwd_gp;
    logic                      r_fwd_gp_we;
    logic [DATA_W-1:0]         r_fwd_result;

    logic                      w_commit;
    logic                      w_gp_we;
    logic                      w_sr_we;
    logic                      w_is_hlt;
    logic [1:0][TGT_GP_W-1:0]  w_gp_rd_addr;
    logic [1:0][DATA_W-1:0]    w_gp_rd_data;
    logic [0:0][TGT_SR_W-1:0]  w_sr_rd_addr;
    logic [0:0][DATA_W-1:0]    w_sr_rd_data;
    logic                      w_unused_instr;

    assign w_unused_instr = ^iw_instr;

    // Gating the enables also disables the read bypass once halted.
    assign w_commit = !r_halted;
    assign w_gp_we  = w_commit && iw_tgt_gp_we;
    assign w_sr_we  = w_commit && iw_tgt_sr_we;
    assign w_is_hlt = (iw_opc == OPC_W'(OPC_S_HLT));

    assign w_gp_rd_addr = {iw_rd_gp_b, iw_rd_gp_a};
    assign w_sr_rd_addr = iw_rd_sr;

    regfile_bypass #(.DW(DATA_W), .AW(TGT_GP_W), .N_RD(2)) u_gp (
        .iw_clk    (iw_clk),
        .iw_rst    (iw_rst),
        .i_we      (w_gp_we),
        .i_waddr   (iw_tgt_gp),
        .i_wdata   (iw_result),
        .i_rd_addr (w_gp_rd_addr),
        .o_rd_data (w_gp_rd_data)
    );

    regfile_bypass #(.DW(DATA_W), .AW(TGT_SR_W), .N_RD(1)) u_sr (
        .iw_clk    (iw_clk),
        .iw_rst    (iw_rst),
        .i_we      (w_sr_we),
        .i_waddr   (iw_tgt_sr),
        .i_wdata   (iw_result),
        .i_rd_addr (w_sr_rd_addr),
        .o_rd_data (w_sr_rd_data)
    );

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_halted     <= 1'b0;
            r_halt_pc    <= '0;
            r_retired    <= '0;
            r_fwd_gp     <= '0;
            r_fwd_gp_we  <= 1'b0;
            r_fwd_result <= '0;
        end else begin
            r_fwd_gp     <= iw_tgt_gp;
            r_fwd_gp_we  <= w_gp_we;
            r_fwd_result <= iw_result;
            if (w_commit && (iw_opc != '0)) begin
                r_retired <= r_retired + 1'b1;
            end
            if (w_commit && w_is_hlt) begin
                r_halted  <= 1'b1;
                r_halt_pc <= iw_pc;
            end
        end
    end

    assign ow_rd_gp_a    = w_gp_rd_data[0];
    assign ow_rd_gp_b    = w_gp_rd_data[1];
    assign ow_rd_sr      = w_sr_rd_data[0];
    assign ow_fwd_gp     = r_fwd_gp;
    assign ow_fwd_gp_we  = r_fwd_gp_we;
    assign ow_fwd_result = r_fwd_result;
    assign ow_retired    = r_retired;
    assign ow_halted     = r_halted;
    assign ow_halt_pc    = r_halt_pc;
endmodule

// File: tb/tb_stg5wb.sv
// Bench for stg5wb: directed literal checks plus randomized traffic compared
// every negedge against an array/counter model of the write-back rules.
module tb_stg5wb;
    import stg5wb_pkg::*;

    logic        iw_clk;
    logic        iw_rst;
    logic [23:0] iw_pc;
    logic [23:0] iw_instr;
    logic [7:0]  iw_opc;
    logic [3:0]  iw_tgt_gp;
    logic        iw_tgt_gp_we;
    logic [1:0]  iw_tgt_sr;
    logic        iw_tgt_sr_we;
    logic [23:0] iw_result;
    logic [3:0]  iw_rd_gp_a;
    logic [23:0] ow_rd_gp_a;
    logic [3:0]  iw_rd_gp_b;
    logic [23:0] ow_rd_gp_b;
    logic [1:0]  iw_rd_sr;
    logic [23:0] ow_rd_sr;
    logic [3:0]  ow_fwd_gp;
    logic        ow_fwd_gp_we;
    logic [23:0] ow_fwd_result;
    logic [31:0] ow_retired;
    logic        ow_halted;
    logic [23:0] ow_halt_pc;

    int n_checks = 0;
    int n_errors = 0;

    stg5wb dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_pc(iw_pc), .iw_instr(iw_instr),
        .iw_opc(iw_opc), .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
        .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we), .iw_result(iw_result),
        .iw_rd_gp_a(iw_rd_gp_a), .ow_rd_gp_a(ow_rd_gp_a),
        .iw_rd_gp_b(iw_rd_gp_b), .ow_rd_gp_b(ow_rd_gp_b),
        .iw_rd_sr(iw_rd_sr), .ow_rd_sr(ow_rd_sr),
        .ow_fwd_gp(ow_fwd_gp), .ow_fwd_gp_we(ow_fwd_gp_we), .ow_fwd_result(ow_fwd_result),
        .ow_retired(ow_retired), .ow_halted(ow_halted), .ow_halt_pc(ow_halt_pc)
    );

    initial begin
        iw_clk = 1'b0;
        forever #5 iw_clk = ~iw_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state as plain arrays and counters.
    logic [23:0] gp_m [16];
    logic [23:0] sr_m [4];
    logic [31:0] cnt_m;
    logic        halt_m;
    logic [23:0] hpc_m;
    logic [3:0]  fgp_m;
    logic        fwe_m;
    logic [23:0] fres_m;
    logic        preload;

    always @(posedge iw_clk or posedge iw_rst or posedge preload) begin
        if (iw_rst) begin
            for (int i = 0; i < 16; i++) gp_m[i] <= '0;
            for (int i = 0; i < 4; i++)  sr_m[i] <= '0;
            cnt_m <= '0; halt_m <= 1'b0; hpc_m <= '0;
            fgp_m <= '0; fwe_m <= 1'b0; fres_m <= '0;
        end else if (preload) begin
            cnt_m <= 32'hFFFF_FFFF;
        end else begin
            fgp_m  <= iw_tgt_gp;
            fwe_m  <= !halt_m && iw_tgt_gp_we;
            fres_m <= iw_result;
            if (!halt_m) begin
                if (iw_tgt_gp_we) gp_m[iw_tgt_gp] <= iw_result;
                if (iw_tgt_sr_we) sr_m[iw_tgt_sr] <= iw_result;
                if (iw_opc != 8'd0) cnt_m <= cnt_m + 32'd1;
                if (iw_opc == OPC_S_HLT) begin
                    halt_m <= 1'b1;
                    hpc_m  <= iw_pc;
                end
            end
        end
    end

    function automatic logic [23:0] exp_gp(input logic [3:0] idx);
        return (!halt_m && iw_tgt_gp_we && iw_tgt_gp == idx) ? iw_result : gp_m[idx];
    endfunction

    function automatic logic [23:0] exp_sr(input logic [1:0] idx);
        return (!halt_m && iw_tgt_sr_we && iw_tgt_sr == idx) ? iw_result : sr_m[idx];
    endfunction

    always @(negedge iw_clk) begin
        chk("m_rd_gp_a", 32'(ow_rd_gp_a), 32'(exp_gp(iw_rd_gp_a)));
        chk("m_rd_gp_b", 32'(ow_rd_gp_b), 32'(exp_gp(iw_rd_gp_b)));
        chk("m_rd_sr", 32'(ow_rd_sr), 32'(exp_sr(iw_rd_sr)));
        chk("m_fwd_gp", 32'(ow_fwd_gp), 32'(fgp_m));
        chk("m_fwd_gp_we", 32'(ow_fwd_gp_we), 32'(fwe_m));
        chk("m_fwd_result", 32'(ow_fwd_result), 32'(fres_m));
        chk("m_retired", ow_retired, cnt_m);
        chk("m_halted", 32'(ow_halted), 32'(halt_m));
        chk("m_halt_pc", 32'(ow_halt_pc), 32'(hpc_m));
        // Stage 4 must never send a write enable with a bubble.
        chk("upstream_bubble_we", 32'(iw_opc == 8'd0 && (iw_tgt_gp_we || iw_tgt_sr_we)), 32'd0);
    end

    task automatic drive(input logic [7:0] opc, input logic [3:0] gp, input logic gwe,
                         input logic [1:0] sr, input logic swe, input logic [23:0] res,
                         input logic [23:0] pc);
        iw_opc = opc; iw_tgt_gp = gp; iw_tgt_gp_we = gwe;
        iw_tgt_sr = sr; iw_tgt_sr_we = swe; iw_result = res;
        iw_pc = pc; iw_instr = res ^ 24'h5A5A5A;
    endtask

    task automatic bubble();
        drive(8'd0, 4'd0, 1'b0, 2'd0, 1'b0, 24'd0, 24'd0);
    endtask

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic rand_cycle(input logic allow_hlt);
        logic [7:0] opc;
        if ($urandom_range(0, 3) == 0) begin
            bubble();
        end else begin
            opc = 8'($urandom_range(1, 126));
            if (allow_hlt && $urandom_range(0, 40) == 0) opc = OPC_S_HLT;
            drive(opc, 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                  24'($urandom), 24'($urandom));
        end
        iw_rd_gp_a = 4'($urandom);
        iw_rd_gp_b = ($urandom_range(0, 1) == 0) ? iw_tgt_gp : 4'($urandom);
        iw_rd_sr   = ($urandom_range(0, 1) == 0) ? iw_tgt_sr : 2'($urandom);
        tick();
    endtask

    initial begin
        preload = 1'b0;
        iw_rst = 1'b1;
        bubble();
        iw_rd_gp_a = '0; iw_rd_gp_b = '0; iw_rd_sr = '0;
        repeat (2) tick();
        iw_rst = 1'b0;

        // Reset state: every register reads back zero.
        for (int i = 0; i < 16; i++) begin
            iw_rd_gp_a = 4'(i);
            #1 chk("rst_gp", 32'(ow_rd_gp_a), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            iw_rd_sr = 2'(i);
            #1 chk("rst_sr", 32'(ow_rd_sr), 32'd0);
        end
        chk("rst_retired", ow_retired, 32'd0);
        chk("rst_halted", 32'(ow_halted), 32'd0);
        tick();

        // Same-cycle bypass, then the forwarding latch one cycle later.
        drive(8'd1, 4'd3, 1'b1, 2'd0, 1'b0, 24'h00ABCD, 24'h000010);
        iw_rd_gp_a = 4'd3;
        #1 chk("bypass_gp_a", 32'(ow_rd_gp_a), 32'h00ABCD);
        tick();
        chk("fwd_gp", 32'(ow_fwd_gp), 32'd3);
        chk("fwd_gp_we", 32'(ow_fwd_gp_we), 32'd1);
        chk("fwd_result", 32'(ow_fwd_result), 32'h00ABCD);

        // GP and SR written in the same cycle, then SR overwritten alone.
        drive(8'd2, 4'd5, 1'b1, 2'd2, 1'b1, 24'h000011, 24'h000014);
        tick();
        bubble();
        iw_rd_gp_b = 4'd5; iw_rd_sr = 2'd2;
        #1 chk("dual_gp_b", 32'(ow_rd_gp_b), 32'h000011);
        chk("dual_sr", 32'(ow_rd_sr), 32'h000011);
        drive(8'd3, 4'd0, 1'b0, 2'd2, 1'b1, 24'h000022, 24'h000018);
        tick();
        bubble();
        #1 chk("sr_only_gp_b", 32'(ow_rd_gp_b), 32'h000011);
        chk("sr_only_sr", 32'(ow_rd_sr), 32'h000022);
        tick();

        // 10 instructions interleaved with 4 bubbles: 3 retired so far + 10.
        for (int k = 0; k < 14; k++) begin
            if (k == 2 || k == 5 || k == 9 || k == 12) bubble();
            else drive(8'(k + 4), 4'(k), 1'b1, 2'(k), 1'b0, 24'(k * 24'h111), 24'(k * 4));
            tick();
        end
        bubble();
        #1 chk("retired_13", ow_retired, 32'd13);

        // Counter wrap: preload all-ones, retire two.
        force dut.r_retired = 32'hFFFF_FFFF;
        preload = 1'b1;
        #1 preload = 1'b0;
        release dut.r_retired;
        tick();
        drive(8'd9, 4'd0, 1'b0, 2'd0, 1'b0, 24'd0, 24'h000100);
        tick();
        drive(8'd9, 4'd0, 1'b0, 2'd0, 1'b0, 24'd0, 24'h000104);
        tick();
        bubble();
        #1 chk("retired_wrap", ow_retired, 32'd1);
        tick();

        // Randomized traffic (no halt).
        for (int k = 0; k < 300; k++) rand_cycle(1'b0);

        // Halt: HLT's own writes land, later writes do not.
        drive(8'd1, 4'd1, 1'b1, 2'd0, 1'b0, 24'h0055AA, 24'h00003C);
        tick();
        drive(OPC_S_HLT, 4'd7, 1'b1, 2'd3, 1'b1, 24'h00BEEF, 24'h000040);
        tick();
        chk("halted", 32'(ow_halted), 32'd1);
        chk("halt_pc", 32'(ow_halt_pc), 32'h000040);
        chk("hlt_fwd_we", 32'(ow_fwd_gp_we), 32'd1);
        drive(8'd1, 4'd1, 1'b1, 2'd3, 1'b1, 24'h123456, 24'h000044);
        iw_rd_gp_a = 4'd1; iw_rd_gp_b = 4'd7; iw_rd_sr = 2'd3;
        #1 chk("halt_no_bypass", 32'(ow_rd_gp_a), 32'h0055AA);
        chk("hlt_wrote_gp", 32'(ow_rd_gp_b), 32'h00BEEF);
        chk("hlt_wrote_sr", 32'(ow_rd_sr), 32'h00BEEF);
        tick();
        chk("halt_gp1_kept", 32'(ow_rd_gp_a), 32'h0055AA);
        chk("halt_fwd_we", 32'(ow_fwd_gp_we), 32'd0);
        for (int k = 0; k < 20; k++) rand_cycle(1'b1);

        // Asynchronous reset mid-cycle while halted with state populated.
        drive(8'd1, 4'd1, 1'b1, 2'd0, 1'b0, 24'h123456, 24'h000048);
        iw_rd_gp_a = 4'd1; iw_rd_gp_b = 4'd7; iw_rd_sr = 2'd3;
        #2 bubble();
        iw_rst = 1'b1;
        #1 chk("arst_retired", ow_retired, 32'd0);
        chk("arst_halted", 32'(ow_halted), 32'd0);
        chk("arst_halt_pc", 32'(ow_halt_pc), 32'd0);
        chk("arst_fwd_result", 32'(ow_fwd_result), 32'd0);
        chk("arst_gp1", 32'(ow_rd_gp_a), 32'd0);
        chk("arst_gp7", 32'(ow_rd_gp_b), 32'd0);
        chk("arst_sr3", 32'(ow_rd_sr), 32'd0);
        tick();
        iw_rst = 1'b0;
        drive(8'd1, 4'd2, 1'b1, 2'd0, 1'b0, 24'h000777, 24'h000000);
        tick();
        bubble();
        iw_rd_gp_a = 4'd2;
        #1 chk("post_rst_gp2", 32'(ow_rd_gp_a), 32'h000777);
        chk("post_rst_retired", ow_retired, 32'd1);
        for (int k = 0; k < 50; k++) rand_cycle(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
